// File: rtl/hex_cmd_pkg.sv
// hex_cmd_pkg: shared states, ASCII constants, error codes and hex decoding (HEX_CMD_ADDR_EN adds the ADDR parser state)
package hex_cmd_pkg;
    localparam int ADDR_W = 27;
    localparam int DATA_W = 16;
    localparam logic [7:0] ASC_W     = 8'h57;
    localparam logic [7:0] ASC_R     = 8'h52;
    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_SP    = 8'h20;
    localparam logic [1:0] ERR_FRAME   = 2'd0;
    localparam logic [1:0] ERR_SYNTAX  = 2'd1;
    localparam logic [1:0] ERR_OVERRUN = 2'd2;
    typedef enum logic [2:0] {RX_ARM, RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`ifdef HEX_CMD_ADDR_EN
    typedef enum logic [2:0] {P_IDLE, P_ADDR, P_COLON, P_DATA, P_EOL, P_HOLD, P_RESYNC} ps_t;
`else
    typedef enum logic [2:0] {P_IDLE, P_COLON, P_DATA, P_EOL, P_HOLD, P_RESYNC} ps_t;
`endif
    typedef struct packed {
        logic       ok;
        logic [3:0] nib;
    } hex_t;
    function automatic hex_t hex_decode(input logic [7:0] c);
        hex_t h;
        h.ok  = 1'b1;
        h.nib = 4'd0;
        if (c >= 8'h30 && c <= 8'h39) h.nib = 4'(c - 8'h30);
        else if (c >= 8'h41 && c <= 8'h46) h.nib = 4'(c - 8'h37);
        else if (c >= 8'h61 && c <= 8'h66) h.nib = 4'(c - 8'h57);
        else h.ok = 1'b0;
        return h;
    endfunction
endpackage

// File: rtl/hex_cmd_if.sv
// hex_cmd_if: valid/ready command port from the hex line parser to the DRAM test sequencer
interface hex_cmd_if
    import hex_cmd_pkg::*;
();
    logic              valid;
    logic              ready;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    modport master(output valid, write, addr, data, input ready);
    modport slave(input valid, write, addr, data, output ready);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with 2-FF synchroniser, idle-line arming, byte strobe and framing error
module uart_rx
    import hex_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       strobe,
    output logic       ferr,
    output logic       active
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    rx_state_t st, st_d;
    logic [CW-1:0] cnt;
    logic [2:0] bit_n;
    logic [7:0] sr;
    logic s1, s2, tick;
    assign tick = cnt == LAST;
    // state register
    always_ff @(posedge clk) st <= !rst_n ? RX_ARM : st_d;
    // next state: arm on a full idle bit, glitch-filter the start bit, frame errors re-arm on idle
    always_comb begin
        st_d = st;
        case (st)
            RX_ARM:   if (s2 && tick) st_d = RX_IDLE;
            RX_IDLE:  if (!s2) st_d = RX_START;
            RX_START: if (cnt == HALF) st_d = s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick && bit_n == 3'd7) st_d = RX_STOP;
            RX_STOP:  if (tick) st_d = s2 ? RX_IDLE : RX_ARM;
            default:  st_d = RX_ARM;
        endcase
    end
    // outputs: strobe or framing error exactly at the stop-bit sample
    always_comb begin
        strobe = st == RX_STOP && tick && s2;
        ferr   = st == RX_STOP && tick && !s2;
        active = st == RX_START || st == RX_DATA || st == RX_STOP;
        data   = sr;
    end
    // synchroniser, bit timer, bit index and LSB-first shift register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {s2, s1} <= 2'b11;
            cnt      <= '0;
            bit_n    <= '0;
            sr       <= '0;
        end else begin
            {s2, s1} <= {s1, rx};
            cnt      <= (st_d != st || st == RX_IDLE || (st == RX_ARM && !s2) || (st == RX_DATA && tick)) ? '0 : cnt + 1'b1;
            bit_n    <= st == RX_DATA ? bit_n + 3'(tick) : '0;
            if (st == RX_DATA && tick) sr <= {s2, sr[7:1]};
        end
    end
endmodule

// File: rtl/hex_cmd_rx.sv
// hex_cmd_rx: UART receiver plus "W:DDDD"/"R" line parser; HEX_CMD_ADDR_EN enables a 7-hex-digit address field
module hex_cmd_rx
    import hex_cmd_pkg::*;
#(
    parameter int                CLKS_PER_BIT = 868,
    parameter logic [ADDR_W-1:0] DEFAULT_ADDR = 27'h0000100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    hex_cmd_if.master  cmd,
    output logic       err,
    output logic [1:0] err_code,
    output logic       rx_active
);
    ps_t ps, ps_d;
    logic [7:0] rb;
    logic stb, ferr, syn, ovr, drop_mid, pend, wr_q;
    logic is_w, is_r, is_eol, is_col, is_sp;
    logic [2:0] cnt;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] addr_q;
    hex_t h;
    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk(clk), .rst_n(rst_n), .rx(uart_rx), .data(rb), .strobe(stb), .ferr(ferr), .active(rx_active)
    );
    assign h      = hex_decode(rb);
    assign is_w   = (rb & 8'hDF) == ASC_W;
    assign is_r   = (rb & 8'hDF) == ASC_R;
    assign is_eol = rb == ASC_CR || rb == ASC_LF;
    assign is_col = rb == ASC_COLON;
    assign is_sp  = rb == ASC_SP;
    assign ovr    = ps == P_HOLD && stb;
    // a resync is only owed while the bytes dropped during HOLD left us mid-line
    assign drop_mid = stb ? !is_eol : pend;
    // state register
    always_ff @(posedge clk) ps <= !rst_n ? P_IDLE : ps_d;
    // next state and syntax-error detection, one decision per received byte
    always_comb begin
        ps_d = ps;
        syn  = 1'b0;
        if (ps == P_HOLD) begin
            if (cmd.ready) ps_d = drop_mid ? P_RESYNC : P_IDLE;
        end else if (stb) begin
            case (ps)
`ifdef HEX_CMD_ADDR_EN
                P_IDLE: if (is_w || is_r) ps_d = P_ADDR;
                        else syn = !(is_eol || is_sp);
                P_ADDR: if (cnt == 3'd0 && wr_q && is_col) ps_d = P_DATA;
                        else if (cnt == 3'd0 && !wr_q && is_eol) ps_d = P_HOLD;
                        else if (h.ok && !(cnt == 3'd0 && h.nib[3])) begin
                            if (cnt == 3'd6) ps_d = wr_q ? P_COLON : P_EOL;
                        end else syn = 1'b1;
`else
                P_IDLE: if (is_w || is_r) ps_d = is_w ? P_COLON : P_EOL;
                        else syn = !(is_eol || is_sp);
`endif
                P_COLON:  if (is_col) ps_d = P_DATA; else syn = 1'b1;
                P_DATA:   if (!h.ok) syn = 1'b1; else if (cnt == 3'd3) ps_d = P_EOL;
                P_EOL:    if (is_eol) ps_d = P_HOLD; else syn = 1'b1;
                P_RESYNC: if (is_eol) ps_d = P_IDLE;
                default:  ps_d = P_IDLE;
            endcase
            if (syn) ps_d = P_RESYNC;
        end
    end
    // command outputs are held registers, valid only in HOLD
    always_comb begin
        cmd.valid = ps == P_HOLD;
        cmd.write = wr_q;
        cmd.addr  = addr_q;
        cmd.data  = data_q;
    end
    // field capture, digit counting, resync-pending flag and error pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q   <= '0;
            addr_q   <= DEFAULT_ADDR;
            wr_q     <= 1'b0;
            cnt      <= '0;
            pend     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_FRAME;
        end else begin
            cnt  <= ps_d != ps ? '0 : cnt + 3'(stb && h.ok);
            pend <= ps == P_HOLD && !cmd.ready && drop_mid;
            if (ps == P_IDLE && stb && (is_w || is_r)) begin
                wr_q   <= is_w;
                data_q <= '0;
                addr_q <= DEFAULT_ADDR;
            end
            if (ps == P_DATA && stb && h.ok) data_q <= {data_q[DATA_W-5:0], h.nib};
`ifdef HEX_CMD_ADDR_EN
            if (ps == P_ADDR && stb && h.ok) addr_q <= {addr_q[ADDR_W-5:0], h.nib};
`endif
            err      <= ferr || syn || ovr;
            err_code <= ferr ? ERR_FRAME : syn ? ERR_SYNTAX : ovr ? ERR_OVERRUN : err_code;
        end
    end
endmodule

// File: tb/tb_hex_cmd_rx.sv
// tb_hex_cmd_rx: directed self-checking bench for hex_cmd_rx (HEX_CMD_ADDR_EN selects the address-field test)
`timescale 1ns/1ps
module tb_hex_cmd_rx;
    localparam int CPB = 16;
    logic clk = 0, rst_n = 0, uart = 1, err, rx_active;
    logic [1:0] err_code;
    hex_cmd_if bus();
    int pass_n = 0, total_n = 0, hs_n = 0, err_n = 0;
    logic [1:0] err_log[$];
    logic last_wr, act_seen;
    logic [26:0] last_addr;
    logic [15:0] last_data;
    hex_cmd_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(uart), .cmd(bus),
        .err(err), .err_code(err_code), .rx_active(rx_active)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (bus.valid && bus.ready) begin
            hs_n++;
            last_wr = bus.write;
            last_addr = bus.addr;
            last_data = bus.data;
        end
        if (err) begin
            err_n++;
            err_log.push_back(err_code);
        end
    end
    function automatic logic [1:0] code_at(int i);
        return i < err_log.size() ? err_log[i] : 2'bxx;
    endfunction
    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk); uart = 0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) act_seen = rx_active;
            uart = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart = stop;
        repeat (CPB) @(negedge clk);
        uart = 1;
        repeat (2 * CPB) @(negedge clk);
    endtask
    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask
    task automatic handshake();
        @(posedge clk); #1 bus.ready = 1;
        @(posedge clk); #1 bus.ready = 0;
        @(negedge clk);
    endtask
    task automatic test_reset();
        bus.ready = 0;
        repeat (4) @(negedge clk);
        total_n += 7;
        if (bus.valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.valid); else pass_n++;
        if (bus.write !== 1'b0) $display("FAIL reset_write got %b want 0", bus.write); else pass_n++;
        if (bus.addr !== 27'h0000100) $display("FAIL reset_addr got %h want 0000100", bus.addr); else pass_n++;
        if (bus.data !== 16'h0) $display("FAIL reset_data got %h want 0000", bus.data); else pass_n++;
        if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else pass_n++;
        if (err_code !== 2'd0) $display("FAIL reset_code got %0d want 0", err_code); else pass_n++;
        if (rx_active !== 1'b0) $display("FAIL reset_active got %b want 0", rx_active); else pass_n++;
        rst_n = 1;
        repeat (3 * CPB) @(negedge clk);
    endtask
    task automatic test_write();
        int h0 = hs_n, e0 = err_n;
        bus.ready = 1;
        send_str("W:A5A5\r\n");
        repeat (4) @(negedge clk);
        total_n += 7;
        if (hs_n - h0 !== 1) $display("FAIL wr_count got %0d want 1", hs_n - h0); else pass_n++;
        if (last_wr !== 1'b1) $display("FAIL wr_write got %b want 1", last_wr); else pass_n++;
        if (last_data !== 16'hA5A5) $display("FAIL wr_data got %h want a5a5", last_data); else pass_n++;
        if (last_addr !== 27'h0000100) $display("FAIL wr_addr got %h want 0000100", last_addr); else pass_n++;
        if (err_n - e0 !== 0) $display("FAIL wr_noerr got %0d want 0", err_n - e0); else pass_n++;
        if (act_seen !== 1'b1) $display("FAIL rx_active_mid got %b want 1", act_seen); else pass_n++;
        if (rx_active !== 1'b0) $display("FAIL rx_active_idle got %b want 0", rx_active); else pass_n++;
        bus.ready = 0;
    endtask
    task automatic test_read_hold();
        int h0 = hs_n, held = 0;
        send_str("r\n");
        total_n += 3;
        if (bus.valid !== 1'b1) $display("FAIL rd_valid got %b want 1", bus.valid); else pass_n++;
        if (bus.write !== 1'b0) $display("FAIL rd_write got %b want 0", bus.write); else pass_n++;
        if (bus.data !== 16'h0) $display("FAIL rd_data got %h want 0000", bus.data); else pass_n++;
        repeat (50) begin
            @(negedge clk);
            if (bus.valid) held++;
        end
        total_n++;
        if (held !== 50) $display("FAIL rd_held got %0d want 50", held); else pass_n++;
        handshake();
        total_n += 2;
        if (bus.valid !== 1'b0) $display("FAIL rd_drop got %b want 0", bus.valid); else pass_n++;
        if (hs_n - h0 !== 1) $display("FAIL rd_count got %0d want 1", hs_n - h0); else pass_n++;
    endtask
    task automatic test_syntax();
        int h0 = hs_n, e0 = err_n;
        bus.ready = 1;
        send_str("W:12G4\r\n");
        total_n += 3;
        if (err_n - e0 !== 1) $display("FAIL syn_errs got %0d want 1", err_n - e0); else pass_n++;
        if (code_at(e0) !== 2'd1) $display("FAIL syn_code got %0d want 1", code_at(e0)); else pass_n++;
        if (hs_n - h0 !== 0) $display("FAIL syn_nocmd got %0d want 0", hs_n - h0); else pass_n++;
        send_str("W:abcd\n");
        total_n += 2;
        if (hs_n - h0 !== 1) $display("FAIL lc_count got %0d want 1", hs_n - h0); else pass_n++;
        if (last_data !== 16'hABCD) $display("FAIL lc_data got %h want abcd", last_data); else pass_n++;
        bus.ready = 0;
    endtask
    task automatic test_framing();
        int h0 = hs_n, e0 = err_n;
        bus.ready = 1;
        send_byte("W", 1'b1);
        send_byte(":", 1'b0);
        send_str("1234\n");
        total_n += 4;
        if (err_n - e0 !== 2) $display("FAIL fr_errs got %0d want 2", err_n - e0); else pass_n++;
        if (code_at(e0) !== 2'd0) $display("FAIL fr_code0 got %0d want 0", code_at(e0)); else pass_n++;
        if (code_at(e0 + 1) !== 2'd1) $display("FAIL fr_code1 got %0d want 1", code_at(e0 + 1)); else pass_n++;
        if (hs_n - h0 !== 0) $display("FAIL fr_nocmd got %0d want 0", hs_n - h0); else pass_n++;
        bus.ready = 0;
    endtask
    task automatic test_overrun();
        int h0 = hs_n, e0 = err_n, c2 = 0;
        send_str("R\n");
        send_str("W:0000\n");
        for (int i = e0; i < err_n; i++) if (code_at(i) == 2'd2) c2++;
        total_n += 3;
        if (err_n - e0 !== 7) $display("FAIL ov_errs got %0d want 7", err_n - e0); else pass_n++;
        if (c2 !== 7) $display("FAIL ov_codes got %0d want 7", c2); else pass_n++;
        if (bus.valid !== 1'b1 || bus.write !== 1'b0) $display("FAIL ov_hold got %b%b want 10", bus.valid, bus.write); else pass_n++;
        handshake();
        total_n += 2;
        if (hs_n - h0 !== 1) $display("FAIL ov_count got %0d want 1", hs_n - h0); else pass_n++;
        if (last_wr !== 1'b0) $display("FAIL ov_read got %b want 0", last_wr); else pass_n++;
        bus.ready = 1;
        send_str("W:FFFF\n");
        total_n += 2;
        if (hs_n - h0 !== 2) $display("FAIL ov_next got %0d want 2", hs_n - h0); else pass_n++;
        if (last_data !== 16'hFFFF) $display("FAIL ov_data got %h want ffff", last_data); else pass_n++;
        bus.ready = 0;
    endtask
    task automatic test_back_to_back();
        int h0 = hs_n, e0 = err_n;
        send_str("R\n");
        send_str("W:1");
        handshake();
        bus.ready = 1;
        send_str("W:2222\n");
        total_n += 2;
        if (hs_n - h0 !== 1) $display("FAIL rs_discard got %0d want 1", hs_n - h0); else pass_n++;
        if (err_n - e0 !== 3) $display("FAIL rs_errs got %0d want 3", err_n - e0); else pass_n++;
        send_str("W:3333\n");
        total_n += 2;
        if (hs_n - h0 !== 2) $display("FAIL rs_next got %0d want 2", hs_n - h0); else pass_n++;
        if (last_data !== 16'h3333) $display("FAIL rs_data got %h want 3333", last_data); else pass_n++;
        bus.ready = 0;
    endtask
    task automatic test_addr_field();
        int h0 = hs_n, e0 = err_n;
        bus.ready = 1;
`ifdef HEX_CMD_ADDR_EN
        send_str("W1ABCDEF:5555\n");
        total_n += 3;
        if (hs_n - h0 !== 1) $display("FAIL ad_count got %0d want 1", hs_n - h0); else pass_n++;
        if (last_addr !== 27'h1ABCDEF) $display("FAIL ad_addr got %h want 1abcdef", last_addr); else pass_n++;
        if (last_data !== 16'h5555) $display("FAIL ad_data got %h want 5555", last_data); else pass_n++;
        send_str("R8000000\n");
`else
        send_str("W1:1234\n");
`endif
        total_n += 2;
        if (err_n - e0 !== 1 || code_at(e0) !== 2'd1) $display("FAIL ad_err got %0d/%0d want 1/1", err_n - e0, code_at(e0)); else pass_n++;
        if (hs_n - h0 !== `ifdef HEX_CMD_ADDR_EN 1 `else 0 `endif) $display("FAIL ad_reject got %0d", hs_n - h0); else pass_n++;
        send_str("R\n");
        total_n++;
        if (last_addr !== 27'h0000100 || last_wr !== 1'b0) $display("FAIL ad_default got %h want 0000100", last_addr); else pass_n++;
        bus.ready = 0;
    endtask
    task automatic test_reset_mid();
        int h0, e0;
        send_str("R\n");
        @(negedge clk); uart = 0;
        repeat (3 * CPB) @(negedge clk);
        total_n++;
        if (rx_active !== 1'b1 || bus.valid !== 1'b1) $display("FAIL rm_pre got %b%b want 11", rx_active, bus.valid); else pass_n++;
        rst_n = 0;
        @(negedge clk);
        total_n += 2;
        if (bus.valid !== 1'b0) $display("FAIL rm_valid got %b want 0", bus.valid); else pass_n++;
        if (rx_active !== 1'b0) $display("FAIL rm_active got %b want 0", rx_active); else pass_n++;
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (4 * CPB) @(negedge clk);
        total_n++;
        if (rx_active !== 1'b0 || err !== 1'b0) $display("FAIL rm_armed got %b%b want 00", rx_active, err); else pass_n++;
        uart = 1;
        repeat (2 * CPB) @(negedge clk);
        h0 = hs_n;
        e0 = err_n;
        bus.ready = 1;
        send_str("W:1357\n");
        total_n += 2;
        if (hs_n - h0 !== 1 || last_data !== 16'h1357) $display("FAIL rm_decode got %0d/%h want 1/1357", hs_n - h0, last_data); else pass_n++;
        if (err_n - e0 !== 0) $display("FAIL rm_noerr got %0d want 0", err_n - e0); else pass_n++;
        bus.ready = 0;
    endtask
    initial begin
        bus.ready = 0;
        test_reset();
        test_write();
        test_read_hold();
        test_syntax();
        test_framing();
        test_overrun();
        test_back_to_back();
        test_addr_field();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
